// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states, flag bit positions
// and opcode classification helpers.
// Rotate opcodes are legal only when ALU_ITER_ROTATE_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SRL = 4'd8,
        OP_SLL = 4'd9,
        OP_SRA = 4'd10,
        OP_ROR = 4'd11,
        OP_ROL = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned FLAGS_W   = 4;
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_NEG  = 1;
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_COUT = 3;

    // Opcodes resolved combinationally in the accept cycle
    function automatic logic is_core_op(input logic [3:0] op);
        return (op <= 4'd5);
    endfunction

    // Opcodes that walk the working register one bit per cycle
    function automatic logic is_shift_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SRL, OP_SLL, OP_SRA: r = 1'b1;
`ifdef ALU_ITER_ROTATE_EN
            OP_ROR, OP_ROL:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ADD/SUB/logic unit with flag generation.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [3:0]         op,
    output logic [WIDTH-1:0]   f_c,
    output logic [FLAGS_W-1:0] flags_c
);

    logic [WIDTH:0] sum;
    logic           cout;
    logic           ovf;

    // Result, carry and signed overflow for the single-cycle opcodes
    always_comb begin
        sum     = '0;
        f_c     = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        flags_c = '0;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                f_c  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (f_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                f_c  = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (f_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  f_c = a & b;
            OP_OR:   f_c = a | b;
            OP_XOR:  f_c = a ^ b;
            OP_NOT:  f_c = ~a;
            default: f_c = '0;
        endcase
        flags_c[FLAG_COUT] = cout;
        flags_c[FLAG_OVF]  = ovf;
        flags_c[FLAG_NEG]  = f_c[WIDTH-1];
        flags_c[FLAG_ZERO] = (f_c == '0);
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle arithmetic/logic, bit-serial shifts and rotates,
// valid/ready handshake on both sides. ROR/ROL exist only with ALU_ITER_ROTATE_EN.
module alu_iter
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               cin_i,
    input  logic [3:0]         op_i,
    input  logic [SHW-1:0]     shamt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   f_o,
    output logic [FLAGS_W-1:0] flags_o,
    output logic               err_o
);

    state_e              state;
    logic [WIDTH-1:0]    work;
    logic [SHW-1:0]      cnt;
    logic [3:0]          op_q;
    logic [WIDTH-1:0]    core_f_c;
    logic [FLAGS_W-1:0]  core_flags_c;
    logic [WIDTH-1:0]    step_c;
    logic                out_bit_c;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (a_i),
        .b       (b_i),
        .cin     (cin_i),
        .op      (op_i),
        .f_c     (core_f_c),
        .flags_c (core_flags_c)
    );

    function automatic logic [FLAGS_W-1:0] mk_flags(input logic [WIDTH-1:0] r, input logic c);
        logic [FLAGS_W-1:0] fl;
        fl            = '0;
        fl[FLAG_COUT] = c;
        fl[FLAG_NEG]  = r[WIDTH-1];
        fl[FLAG_ZERO] = (r == '0);
        return fl;
    endfunction

    // One-bit move of the working register and the bit that leaves it
    always_comb begin
        step_c    = work;
        out_bit_c = 1'b0;
        case (op_q)
            OP_SRL: begin
                step_c    = {1'b0, work[WIDTH-1:1]};
                out_bit_c = work[0];
            end
            OP_SRA: begin
                step_c    = {work[WIDTH-1], work[WIDTH-1:1]};
                out_bit_c = work[0];
            end
            OP_SLL: begin
                step_c    = {work[WIDTH-2:0], 1'b0};
                out_bit_c = work[WIDTH-1];
            end
`ifdef ALU_ITER_ROTATE_EN
            OP_ROR: begin
                step_c    = {work[0], work[WIDTH-1:1]};
                out_bit_c = work[0];
            end
            OP_ROL: begin
                step_c    = {work[WIDTH-2:0], work[WIDTH-1]};
                out_bit_c = work[WIDTH-1];
            end
`endif
            default: begin
                step_c    = work;
                out_bit_c = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            f_o         <= '0;
            flags_o     <= '0;
            err_o       <= 1'b0;
            cnt         <= '0;
            work        <= '0;
            op_q        <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        in_ready_o <= 1'b0;
                        op_q       <= op_i;
                        work       <= a_i;
                        cnt        <= shamt_i;
                        if (is_core_op(op_i)) begin
                            f_o         <= core_f_c;
                            flags_o     <= core_flags_c;
                            err_o       <= 1'b0;
                            out_valid_o <= 1'b1;
                            state       <= ST_DONE;
                        end else if (is_shift_op(op_i)) begin
                            if (shamt_i == '0) begin
                                f_o         <= a_i;
                                flags_o     <= mk_flags(a_i, 1'b0);
                                err_o       <= 1'b0;
                                out_valid_o <= 1'b1;
                                state       <= ST_DONE;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end else begin
                            f_o         <= '0;
                            flags_o     <= '0;
                            err_o       <= 1'b1;
                            out_valid_o <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_c;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        f_o         <= step_c;
                        flags_o     <= mk_flags(step_c, out_bit_c);
                        err_o       <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width, legal range 8..64.
REQ-002 SHALL have derived localparam SHW = $clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1: operation request valid.
REQ-006 SHALL have port in_ready_o, output, 1: block can accept a request.
REQ-007 SHALL have port a_i, input, WIDTH: operand A.
REQ-008 SHALL have port b_i, input, WIDTH: operand B.
REQ-009 SHALL have port cin_i, input, 1: carry-in, used by ADD only.
REQ-010 SHALL have port op_i, input, 4: opcode.
REQ-011 SHALL have port shamt_i, input, SHW: shift/rotate amount.
REQ-012 SHALL have port out_valid_o, output, 1: result valid.
REQ-013 SHALL have port out_ready_i, input, 1: consumer accepts result.
REQ-014 SHALL have port f_o, output, WIDTH: result.
REQ-015 SHALL have port flags_o, output, 4: {cout, ovf, neg, zero}.
REQ-016 SHALL have port err_o, output, 1: opcode was illegal.

Function
REQ-017 Opcodes SHALL be: 0 ADD (a+b+cin), 1 SUB (a+~b+1), 2 AND, 3 OR, 4 XOR, 5 NOT a, 8 SRL, 9 SLL, 10 SRA, 11 ROR, 12 ROL; all others illegal.
REQ-018 FSM SHALL have states IDLE, SHIFT, DONE; in_ready_o = 1 only in IDLE.
REQ-019 Accept occurs when in_valid_i & in_ready_o; a_i, b_i, cin_i, op_i, shamt_i SHALL be captured at accept.
REQ-020 ADD/SUB/logic ops SHALL compute in the accept cycle and enter DONE; out_valid_o rises 1 cycle after accept.
REQ-021 Shift/rotate ops with shamt_i != 0 SHALL enter SHIFT, move the working register 1 bit per cycle, and enter DONE after shamt_i steps; out_valid_o rises shamt_i+1 cycles after accept.
REQ-022 Shift/rotate ops with shamt_i = 0 SHALL go directly to DONE with f_o = a, cout = 0 (latency 1).
REQ-023 SRA SHALL replicate a[WIDTH-1]; SRL/SLL SHALL fill with 0.
REQ-024 In DONE, out_valid_o = 1 and f_o/flags_o/err_o SHALL stay stable until out_ready_i = 1; that cycle returns the FSM to IDLE.
REQ-025 in_ready_o SHALL be 0 in SHIFT and DONE; in_valid_i there SHALL be ignored, with no accept.
REQ-026 cout SHALL be: ADD/SUB carry out of bit WIDTH-1 (SUB: 1 = no borrow); shifts: last bit shifted out; logic: 0.
REQ-027 ovf SHALL be two's-complement signed overflow for ADD/SUB and 0 otherwise.
REQ-028 neg SHALL equal f_o[WIDTH-1] and zero SHALL equal (f_o == 0) for all legal ops.
REQ-029 Illegal opcode SHALL take latency 1 with f_o = 0, flags_o = 0 and err_o = 1; err_o = 0 for legal ops.
REQ-030 Outside DONE, f_o, flags_o and err_o SHALL hold the last result; only out_valid_o qualifies them.

Reset
REQ-031 On rst_ni = 0, asynchronously: state = IDLE, out_valid_o = 0, f_o = 0, flags_o = 0, err_o = 0, shift counter = 0; in_ready_o = 1 once released.
REQ-032 Reset during SHIFT or DONE SHALL abort the operation, and no result is ever presented for it.

Configuration
REQ-033 Macro ALU_ITER_ROTATE_EN: defined, ROR/ROL SHALL be legal (bits wrap around); undefined, opcodes 11/12 SHALL be illegal per REQ-029 and the rotate logic SHALL be absent.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode enum, the FSM state enum and flag bit-index constants.
REQ-035 Sub-module alu_core SHALL be combinational ADD/SUB/logic with flag generation; the FSM and shift datapath SHALL reside in alu_iter.

Verification
REQ-036 ADD a=0xFFFFFFFF, b=0x1, cin=0 -> f_o=0x0, cout=1, zero=1; out_valid_o 1 cycle after accept.
REQ-037 SUB a=0x80000000, b=0x1 -> f_o=0x7FFFFFFF, ovf=1, cout=1, neg=0.
REQ-038 SRA a=0x80000000, shamt=4 -> f_o=0xF8000000, neg=1, cout=0; out_valid_o exactly 5 cycles after accept.
REQ-039 out_ready_i held 0 for 3 cycles in DONE -> f_o and flags_o stable, in_ready_o=0, and no new accept despite in_valid_i=1.
REQ-040 rst_ni pulsed low during SLL with shamt=10 at step 3 -> out_valid_o=0 immediately, in_ready_o=1 after release, and no stale result appears.
REQ-041 ROR a=0x00000001, shamt=1 -> with macro: f_o=0x80000000, err_o=0; without macro: f_o=0, err_o=1.
